// File: rtl/sme_param.sv
// -----------------------------------------------------------------------------
// sme_param -- parametrised string-matching engine
//
// Buffers a string (up to STR_MAX chars) and a pattern (up to PAT_MAX chars),
// then searches for the leftmost start position where the pattern matches.
// Metacharacters: '.' any char, '^' start-of-string or one space, '$'
// end-of-string or one space, '*' zero or more chars with backtracking to the
// most recent '*'. Optional case-insensitive compare of ASCII letters.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   chardata     in   character for the current cycle (DW bits)
//   isstring     in   chardata is a string character
//   ispattern    in   chardata is a pattern character
//   nocase       in   sampled with first pattern char, 1 = fold A-Z onto a-z
//   busy         out  high from the cycle after the last pattern char through
//                     the valid cycle
//   valid        out  one-cycle result strobe
//   match        out  match result, 0 whenever valid = 0
//   match_index  out  leftmost match start, 0 unless valid & match
// -----------------------------------------------------------------------------
module sme_param #(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8,
   parameter int DW      = 8,
   parameter int IW      = $clog2(STR_MAX)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] chardata,
   input  logic          isstring,
   input  logic          ispattern,
   input  logic          nocase,
   output logic          busy,
   output logic          valid,
   output logic          match,
   output logic [IW-1:0] match_index
);

   // String-side indices are one bit wider than IW so a length of STR_MAX fits.
   localparam int SW = IW + 1;
   localparam int PW = $clog2(PAT_MAX) + 1;

   localparam logic [DW-1:0] CH_DOT    = DW'(8'h2E);
   localparam logic [DW-1:0] CH_CARET  = DW'(8'h5E);
   localparam logic [DW-1:0] CH_DOLLAR = DW'(8'h24);
   localparam logic [DW-1:0] CH_STAR   = DW'(8'h2A);
   localparam logic [DW-1:0] CH_SPACE  = DW'(8'h20);

   typedef enum logic [2:0] {
      IDLE,
      RECV_S,
      RECV_P,
      PROC,
      DONE
   } state_t;

   state_t        state_q;

   logic [DW-1:0] str_q [0:STR_MAX-1];
   logic [DW-1:0] pat_q [0:PAT_MAX-1];
   logic [SW-1:0] slen_q;
   logic [PW-1:0] plen_q;
   logic          nocase_q;

   // Search pointers: start position, string cursor, pattern cursor, and the
   // resume point recorded by the most recent '*'.
   logic [SW-1:0] s_q;
   logic [SW-1:0] si_q;
   logic [PW-1:0] pi_q;
   logic          star_v_q;
   logic [PW-1:0] star_p_q;
   logic [SW-1:0] star_s_q;
   logic          adj_q;

   logic          busy_q;
   logic          valid_q;
   logic          match_q;
   logic [IW-1:0] index_q;

   // Step results for the current search cycle.
   logic [SW-1:0] si_d;
   logic [PW-1:0] pi_d;
   logic          star_v_d;
   logic [PW-1:0] star_p_d;
   logic [SW-1:0] star_s_d;
   logic          adj_d;
   logic          hit;
   logic          miss;

   logic [DW-1:0] str_ch;
   logic [DW-1:0] pat_ch;
   logic          si_lt;
   logic          lit_eq;
   logic          can_bt;
   logic [SW-1:0] idx_full;
   logic [SW-1:0] idx_clamp;

   function automatic logic [DW-1:0] fold_case(input logic [DW-1:0] c);
      logic [DW-1:0] r;
      r = c;
      if (c[7:0] >= 8'h41 && c[7:0] <= 8'h5A) begin
         r[5] = 1'b1;
      end
      return r;
   endfunction

   assign si_lt  = (si_q < slen_q);
   assign str_ch = (si_q < SW'(STR_MAX)) ? str_q[si_q[IW-1:0]] : '0;
   assign pat_ch = pat_q[pi_q[PW-2:0]];
   assign lit_eq = nocase_q ? (fold_case(str_ch) == fold_case(pat_ch))
                            : (str_ch == pat_ch);
   // A '*' can absorb one more character only while string chars remain.
   assign can_bt = star_v_q && (star_s_q < slen_q);

   // A leading '*' anchors the report at 0; '^' consuming a leading space
   // reports the position after that space.
   assign idx_full  = (pat_q[0] == CH_STAR) ? '0 : (s_q + SW'(adj_q));
   assign idx_clamp = (idx_full > SW'(STR_MAX - 1)) ? SW'(STR_MAX - 1) : idx_full;

   // One pattern/string step of the matcher at the current start position.
   always_comb begin
      si_d     = si_q;
      pi_d     = pi_q;
      star_v_d = star_v_q;
      star_p_d = star_p_q;
      star_s_d = star_s_q;
      adj_d    = adj_q;
      hit      = 1'b0;
      miss     = 1'b0;
      if (pi_q == plen_q) begin
         hit = 1'b1;
      end else if (pat_ch == CH_STAR) begin
         star_v_d = 1'b1;
         star_p_d = pi_q + PW'(1);
         star_s_d = si_q;
         pi_d     = pi_q + PW'(1);
      end else if (pat_ch == CH_CARET) begin
         if (si_q == '0) begin
            pi_d = pi_q + PW'(1);
         end else if (si_lt && str_ch == CH_SPACE) begin
            si_d = si_q + SW'(1);
            pi_d = pi_q + PW'(1);
            if (si_q == s_q) begin
               adj_d = 1'b1;
            end
         end else begin
            miss = 1'b1;
         end
      end else if (pat_ch == CH_DOLLAR) begin
         if (si_q == slen_q) begin
            pi_d = pi_q + PW'(1);
         end else if (si_lt && str_ch == CH_SPACE) begin
            si_d = si_q + SW'(1);
            pi_d = pi_q + PW'(1);
         end else begin
            miss = 1'b1;
         end
      end else if (pat_ch == CH_DOT) begin
         if (si_lt) begin
            si_d = si_q + SW'(1);
            pi_d = pi_q + PW'(1);
         end else begin
            miss = 1'b1;
         end
      end else begin
         if (si_lt && lit_eq) begin
            si_d = si_q + SW'(1);
            pi_d = pi_q + PW'(1);
         end else begin
            miss = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         slen_q   <= '0;
         plen_q   <= '0;
         nocase_q <= 1'b0;
         for (int i = 0; i < STR_MAX; i++) begin
            str_q[i] <= '0;
         end
         for (int i = 0; i < PAT_MAX; i++) begin
            pat_q[i] <= '0;
         end
         s_q      <= '0;
         si_q     <= '0;
         pi_q     <= '0;
         star_v_q <= 1'b0;
         star_p_q <= '0;
         star_s_q <= '0;
         adj_q    <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         match_q  <= 1'b0;
         index_q  <= '0;
      end else begin
         valid_q <= 1'b0;
         match_q <= 1'b0;
         index_q <= '0;
         case (state_q)
            IDLE, DONE: begin
               busy_q <= 1'b0;
               if (ispattern) begin
                  state_q  <= RECV_P;
                  pat_q[0] <= chardata;
                  plen_q   <= PW'(1);
                  nocase_q <= nocase;
               end else if (isstring) begin
                  state_q  <= RECV_S;
                  str_q[0] <= chardata;
                  slen_q   <= SW'(1);
               end else begin
                  state_q <= IDLE;
               end
            end
            RECV_S: begin
               if (ispattern) begin
                  state_q  <= RECV_P;
                  pat_q[0] <= chardata;
                  plen_q   <= PW'(1);
                  nocase_q <= nocase;
               end else if (isstring && slen_q < SW'(STR_MAX)) begin
                  str_q[slen_q[IW-1:0]] <= chardata;
                  slen_q <= slen_q + SW'(1);
               end
            end
            RECV_P: begin
               if (ispattern) begin
                  if (plen_q < PW'(PAT_MAX)) begin
                     pat_q[plen_q[PW-2:0]] <= chardata;
                     plen_q <= plen_q + PW'(1);
                  end
               end else begin
                  state_q  <= PROC;
                  busy_q   <= 1'b1;
                  s_q      <= '0;
                  si_q     <= '0;
                  pi_q     <= '0;
                  star_v_q <= 1'b0;
                  adj_q    <= 1'b0;
               end
            end
            PROC: begin
               // Host flags are ignored here; characters are dropped.
               if (hit) begin
                  state_q <= DONE;
                  valid_q <= 1'b1;
                  match_q <= 1'b1;
                  index_q <= idx_clamp[IW-1:0];
               end else if (miss) begin
                  if (can_bt) begin
                     star_s_q <= star_s_q + SW'(1);
                     si_q     <= star_s_q + SW'(1);
                     pi_q     <= star_p_q;
                  end else if (s_q == slen_q) begin
                     state_q <= DONE;
                     valid_q <= 1'b1;
                  end else begin
                     s_q      <= s_q + SW'(1);
                     si_q     <= s_q + SW'(1);
                     pi_q     <= '0;
                     star_v_q <= 1'b0;
                     adj_q    <= 1'b0;
                  end
               end else begin
                  si_q     <= si_d;
                  pi_q     <= pi_d;
                  star_v_q <= star_v_d;
                  star_p_q <= star_p_d;
                  star_s_q <= star_s_d;
                  adj_q    <= adj_d;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign valid       = valid_q;
   assign match       = match_q;
   assign match_index = index_q;

endmodule

// File: tb/tb_sme_param.sv
module tb_sme_param;

   localparam int IW      = 5;
   localparam int TIMEOUT = 2000;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    chardata;
   logic          isstring;
   logic          ispattern;
   logic          nocase;
   logic          busy;
   logic          valid;
   logic          match;
   logic [IW-1:0] match_index;

   int n_vec = 0;
   int n_err = 0;

   sme_param #(.STR_MAX(32), .PAT_MAX(8), .DW(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .chardata   (chardata),
      .isstring   (isstring),
      .ispattern  (ispattern),
      .nocase     (nocase),
      .busy       (busy),
      .valid      (valid),
      .match      (match),
      .match_index(match_index)
   );

   always #5 clk = ~clk;

   task automatic send_string(input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(posedge clk); #1;
         isstring = 1'b1;
         chardata = s[i];
      end
      @(posedge clk); #1;
      isstring = 1'b0;
      chardata = 8'h00;
   endtask

   // no_wait drives the first character in the current cycle (back-to-back).
   task automatic send_pattern(input string p, input logic nc, input bit no_wait);
      for (int i = 0; i < p.len(); i++) begin
         if (!(no_wait && i == 0)) begin
            @(posedge clk); #1;
         end
         ispattern = 1'b1;
         chardata  = p[i];
         if (i == 0) nocase = nc;
      end
      @(posedge clk); #1;
      ispattern = 1'b0;
      chardata  = 8'h00;
   endtask

   task automatic wait_result(output bit got, output logic m, output logic [IW-1:0] idx,
                              output int lat, output logic busy_first, output int stray);
      got = 1'b0; m = 1'b0; idx = '0; lat = 0; busy_first = 1'b0; stray = 0;
      for (int c = 1; c <= TIMEOUT; c++) begin
         @(posedge clk); #1;
         if (c == 1) busy_first = busy;
         if (valid) begin
            got = 1'b1; m = match; idx = match_index; lat = c;
            break;
         end
         if (match || match_index != '0) stray++;
      end
   endtask

   task automatic test_reset;
      bit got; logic m; logic [IW-1:0] idx; int lat; logic bf; int stray;
      n_vec++;
      if ({busy, valid, match, match_index} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got busy=%b valid=%b match=%b idx=%0d, need all 0",
                  busy, valid, match, match_index);
      end
      send_pattern("^$", 1'b0, 1'b0);
      wait_result(got, m, idx, lat, bf, stray);
      $display("[tb] empty string, pattern \"^$\" -> valid=%0d match=%0d index=%0d latency=%0d", got, m, idx, lat);
      n_vec++;
      if (!got || m !== 1'b1 || idx !== 5'd0) begin
         n_err++;
         $display("FAIL reset_empty_meta: got valid=%0d match=%0d idx=%0d, need 1/1/0", got, m, idx);
      end
   endtask

   task automatic test_basic;
      bit got; logic m; logic [IW-1:0] idx; int lat; logic bf; int stray;
      send_string("hello world");
      send_pattern("wor", 1'b0, 1'b0);
      wait_result(got, m, idx, lat, bf, stray);
      $display("[tb] \"hello world\" / \"wor\" -> valid=%0d match=%0d index=%0d latency=%0d", got, m, idx, lat);
      n_vec++;
      if (!got || m !== 1'b1 || idx !== 5'd6) begin
         n_err++;
         $display("FAIL basic_wor: got valid=%0d match=%0d idx=%0d, need 1/1/6", got, m, idx);
      end
      n_vec++;
      if (bf !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL basic_busy_high: got first=%b at_valid=%b, need 1/1", bf, busy);
      end
      n_vec++;
      if (lat < 3 || lat > 1389) begin
         n_err++;
         $display("FAIL basic_latency: got %0d, need 3..1389", lat);
      end
      n_vec++;
      if (stray != 0) begin
         n_err++;
         $display("FAIL basic_quiet_outputs: got %0d nonzero samples, need 0", stray);
      end
      @(posedge clk); #1;
      n_vec++;
      if (busy !== 1'b0 || valid !== 1'b0 || match !== 1'b0) begin
         n_err++;
         $display("FAIL basic_after_valid: got busy=%b valid=%b match=%b, need 0/0/0", busy, valid, match);
      end
   endtask

   task automatic test_pattern_only;
      string       pats  [5] = '{"^wor", "o.w", "ld$", "h*d", "^orl"};
      logic        exp_m [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      int          exp_i [5] = '{6, 4, 9, 0, 0};
      bit got; logic m; logic [IW-1:0] idx; int lat; logic bf; int stray;
      for (int k = 0; k < 5; k++) begin
         send_pattern(pats[k], 1'b0, 1'b0);
         wait_result(got, m, idx, lat, bf, stray);
         $display("[tb] pattern-only \"%s\" -> valid=%0d match=%0d index=%0d latency=%0d", pats[k], got, m, idx, lat);
         n_vec++;
         if (!got || m !== exp_m[k] || idx !== IW'(exp_i[k])) begin
            n_err++;
            $display("FAIL pattern_only_%s: got valid=%0d match=%0d idx=%0d, need 1/%0d/%0d",
                     pats[k], got, m, idx, exp_m[k], exp_i[k]);
         end
      end
   endtask

   task automatic test_nocase;
      bit got; logic m; logic [IW-1:0] idx; int lat; logic bf; int stray;
      send_pattern("WOR", 1'b1, 1'b0);
      wait_result(got, m, idx, lat, bf, stray);
      $display("[tb] \"WOR\" nocase=1 -> valid=%0d match=%0d index=%0d", got, m, idx);
      n_vec++;
      if (!got || m !== 1'b1 || idx !== 5'd6) begin
         n_err++;
         $display("FAIL nocase_on: got valid=%0d match=%0d idx=%0d, need 1/1/6", got, m, idx);
      end
      send_pattern("WOR", 1'b0, 1'b0);
      wait_result(got, m, idx, lat, bf, stray);
      $display("[tb] \"WOR\" nocase=0 -> valid=%0d match=%0d index=%0d", got, m, idx);
      n_vec++;
      if (!got || m !== 1'b0 || idx !== 5'd0) begin
         n_err++;
         $display("FAIL nocase_off: got valid=%0d match=%0d idx=%0d, need 1/0/0", got, m, idx);
      end
   endtask

   task automatic test_back_to_back;
      bit got; logic m; logic [IW-1:0] idx; int lat; logic bf; int stray;
      send_pattern("wor", 1'b0, 1'b0);
      wait_result(got, m, idx, lat, bf, stray);
      $display("[tb] b2b first \"wor\" -> valid=%0d match=%0d index=%0d", got, m, idx);
      n_vec++;
      if (!got || m !== 1'b1 || idx !== 5'd6) begin
         n_err++;
         $display("FAIL b2b_first: got valid=%0d match=%0d idx=%0d, need 1/1/6", got, m, idx);
      end
      // Next pattern starts in the valid cycle itself.
      send_pattern("ld$", 1'b0, 1'b1);
      wait_result(got, m, idx, lat, bf, stray);
      $display("[tb] b2b second \"ld$\" -> valid=%0d match=%0d index=%0d", got, m, idx);
      n_vec++;
      if (!got || m !== 1'b1 || idx !== 5'd9) begin
         n_err++;
         $display("FAIL b2b_second: got valid=%0d match=%0d idx=%0d, need 1/1/9", got, m, idx);
      end
   endtask

   task automatic test_busy_ignore;
      bit got; logic m; logic [IW-1:0] idx; int lat; logic bf; int stray;
      send_pattern("o.w", 1'b0, 1'b0);
      @(posedge clk); #1;
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL busy_ignore_busy: got busy=%b, need 1", busy);
      end
      isstring = 1'b1; chardata = "z";
      @(posedge clk); #1;
      isstring = 1'b0; ispattern = 1'b1; chardata = "q";
      @(posedge clk); #1;
      ispattern = 1'b0; chardata = 8'h00;
      wait_result(got, m, idx, lat, bf, stray);
      $display("[tb] \"o.w\" with flags pulsed while busy -> valid=%0d match=%0d index=%0d", got, m, idx);
      n_vec++;
      if (!got || m !== 1'b1 || idx !== 5'd4) begin
         n_err++;
         $display("FAIL busy_ignore_result: got valid=%0d match=%0d idx=%0d, need 1/1/4", got, m, idx);
      end
      send_pattern("hello world", 1'b0, 1'b0);
      wait_result(got, m, idx, lat, bf, stray);
      $display("[tb] string intact check \"hello wo\" -> valid=%0d match=%0d index=%0d", got, m, idx);
      n_vec++;
      if (!got || m !== 1'b1 || idx !== 5'd0) begin
         n_err++;
         $display("FAIL busy_ignore_string: got valid=%0d match=%0d idx=%0d, need 1/1/0", got, m, idx);
      end
   endtask

   task automatic test_overflow;
      bit got; logic m; logic [IW-1:0] idx; int lat; logic bf; int stray;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         isstring = 1'b1;
         chardata = 8'h61 + 8'(i % 26);
      end
      @(posedge clk); #1;
      isstring = 1'b0; chardata = 8'h00;
      send_pattern("*$", 1'b0, 1'b0);
      wait_result(got, m, idx, lat, bf, stray);
      $display("[tb] 40-char string, \"*$\" -> valid=%0d match=%0d index=%0d latency=%0d", got, m, idx, lat);
      n_vec++;
      if (!got || m !== 1'b1 || idx !== 5'd0) begin
         n_err++;
         $display("FAIL overflow_star_dollar: got valid=%0d match=%0d idx=%0d, need 1/1/0", got, m, idx);
      end
      send_pattern("ef$", 1'b0, 1'b0);
      wait_result(got, m, idx, lat, bf, stray);
      $display("[tb] 40-char string, \"ef$\" -> valid=%0d match=%0d index=%0d", got, m, idx);
      n_vec++;
      if (!got || m !== 1'b1 || idx !== 5'd30) begin
         n_err++;
         $display("FAIL overflow_truncated_end: got valid=%0d match=%0d idx=%0d, need 1/1/30", got, m, idx);
      end
   endtask

   task automatic test_long_pattern;
      bit got; logic m; logic [IW-1:0] idx; int lat; logic bf; int stray;
      send_string("hello world");
      send_pattern("lo worldXY", 1'b0, 1'b0);
      wait_result(got, m, idx, lat, bf, stray);
      $display("[tb] 10-char pattern \"lo worldXY\" -> valid=%0d match=%0d index=%0d", got, m, idx);
      n_vec++;
      if (!got || m !== 1'b1 || idx !== 5'd3) begin
         n_err++;
         $display("FAIL long_pattern: got valid=%0d match=%0d idx=%0d, need 1/1/3", got, m, idx);
      end
   endtask

   task automatic test_reset_mid_proc;
      bit got; logic m; logic [IW-1:0] idx; int lat; logic bf; int stray;
      int seen;
      send_string("aaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa");
      send_pattern("*b", 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      n_vec++;
      if (busy !== 1'b1 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL midproc_running: got busy=%b valid=%b, need 1/0", busy, valid);
      end
      reset = 1'b1;
      #1;
      n_vec++;
      if ({busy, valid, match, match_index} !== '0) begin
         n_err++;
         $display("FAIL midproc_async_reset: got busy=%b valid=%b match=%b idx=%0d, need all 0",
                  busy, valid, match, match_index);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         if (valid || busy) seen++;
      end
      $display("[tb] reset during search -> stray valid/busy cycles=%0d", seen);
      n_vec++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL midproc_no_valid: got %0d active cycles, need 0", seen);
      end
      send_pattern("*", 1'b0, 1'b0);
      wait_result(got, m, idx, lat, bf, stray);
      $display("[tb] after reset \"*\" -> valid=%0d match=%0d index=%0d", got, m, idx);
      n_vec++;
      if (!got || m !== 1'b1 || idx !== 5'd0) begin
         n_err++;
         $display("FAIL midproc_star_empty: got valid=%0d match=%0d idx=%0d, need 1/1/0", got, m, idx);
      end
      send_pattern("a", 1'b0, 1'b0);
      wait_result(got, m, idx, lat, bf, stray);
      $display("[tb] after reset \"a\" -> valid=%0d match=%0d index=%0d", got, m, idx);
      n_vec++;
      if (!got || m !== 1'b0 || idx !== 5'd0) begin
         n_err++;
         $display("FAIL midproc_literal_empty: got valid=%0d match=%0d idx=%0d, need 1/0/0", got, m, idx);
      end
   endtask

   initial begin
      reset     = 1'b1;
      chardata  = 8'h00;
      isstring  = 1'b0;
      ispattern = 1'b0;
      nocase    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_pattern_only();
      test_nocase();
      test_back_to_back();
      test_busy_ignore();
      test_overflow();
      test_long_pattern();
      test_reset_mid_proc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sme_param.md
# sme_param

Parametrised string-matching engine, the successor to the fixed 32×8 matcher in the homework string-match path. It buffers a string of up to `STR_MAX` characters and a pattern of up to `PAT_MAX` characters, then searches for the leftmost match. Supported metacharacters: `.`, `^`, `$` and `*`, with optional case-insensitive compare. It reports one `valid` pulse with `match`/`match_index` per pattern, reuses the stored string across pattern-only sessions, and exposes `busy` for host flow control.

## Interface
- `STR_MAX`, default 32: maximum string length, 2..64.
- `PAT_MAX`, default 8: maximum pattern length, 2..16.
- `DW`, default 8: character width (ASCII codes in low 8 bits; upper bits compared literally).
- `IW`, default `$clog2(STR_MAX)`: `match_index` width.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `chardata`  in  DW  character for the current cycle.
- `isstring`  in  1  `chardata` is a string character.
- `ispattern`  in  1  `chardata` is a pattern character.
- `nocase`  in  1  sampled with the first pattern character; 1 = ASCII letters compare case-insensitively.
- `busy`  out  1  high from the cycle after the last pattern character through the `valid` cycle.
- `valid`  out  1  one-cycle result strobe.
- `match`  out  1  result; 0 whenever `valid`=0.
- `match_index`  out  IW  leftmost match start; 0 whenever `valid`=0 or `match`=0.

## Operation
- **States:** IDLE, RECV_S, RECV_P, PROC, DONE.
  - IDLE/DONE -> RECV_S on `isstring`; -> RECV_P on `ispattern`.
  - RECV_S -> RECV_P when `ispattern` rises.
  - RECV_P -> PROC on the first cycle with `ispattern`=0.
  - PROC -> DONE when the search ends.
  - DONE -> IDLE, or straight to RECV_S/RECV_P if the host drives them.
- **Buffering:**
  - Entering RECV_S clears the string length, then stores chars at index 0,1,…
  - Characters beyond `STR_MAX`/`PAT_MAX` are dropped silently; lengths saturate.
  - A pattern-only session reuses the last stored string unchanged.
- **Search:**
  - Try start positions s = 0..len. The first s at which the whole pattern matches wins.
  - `.` matches any one char. A literal matches on equality; with `nocase`, A–Z equals a–z.
  - `^` matches zero-width at position 0, or consumes one space (0x20). On the space, the reported index is s+1.
  - `$` matches zero-width at end of string, or consumes one space.
  - `*` matches zero or more of any char. Multiple `*` are allowed, with backtracking to the most recent `*`.
  - A leading `*` gives index 0 whenever it matches.
- **Empty string:** after reset, or a string of length 0, a pattern made only of `^`, `$`, `*` matches with index 0; any other pattern does not match.
- **Ignored input:** `isstring`/`ispattern` asserted while `busy`=1 is ignored and the characters are dropped.

## Timing
- **Reset:** all outputs 0, state IDLE, both lengths 0, buffers cleared. Reset during PROC aborts with no `valid`.
- **Cycle timing:**
  - Each character is captured on the edge where its flag is high.
  - `busy` rises on the first edge after `ispattern` falls.
  - `valid`, `match` and `match_index` are registered and change together.
  - `busy` falls in the cycle after `valid`.
- **Latency** (last pattern char to `valid`):
  - ≥ 3 cycles.
  - ≤ (STR_MAX+1)·(STR_MAX+PAT_MAX+2)+3 cycles.
  - Per start position: one cycle per pattern/string step, including backtracking.
- **Back-to-back:** a new session may start in the `valid` cycle or any later cycle.
- **Arithmetic:** indices are held 1 bit wider than IW internally (`len` can equal `STR_MAX`). `match_index` < `STR_MAX` always.

## Test plan
- String "hello world", pattern "wor" -> `valid` pulse, `match`=1, `match_index`=6.
- Same string via pattern-only sessions (no string resend):
  - "^wor" -> 1/6
  - "o.w" -> 1/4
  - "ld$" -> 1/9
  - "h*d" -> 1/0
  - "^orl" -> 0/0
- Pattern "WOR" on "hello world": `nocase`=1 -> 1/6; `nocase`=0 -> 0/0.
- Overflow:
  - STR_MAX=32, 40-char string "abc…": chars 32–39 dropped; pattern "$" matches at index 0? No: "$" matches at the end of the 32-char buffer only if there are no spaces; expect 1/32-wrap-free index 31+1 is illegal, so use pattern "*$" -> 1/0.
  - 10-char pattern with PAT_MAX=8: only the first 8 chars are used.
- Reset mid-PROC, then after reset the pattern "*" alone: no `valid` for the aborted run; then 1/0 (empty string rule).
- `isstring` pulsed while `busy`: the stored string is unaltered and the result is identical to the undisturbed run.
